otter_trap_csr: RTL and testbench
=================================

OTTER_TRAP_CSR -- requirements
Module: otter_trap_csr

Interface
REQ-001 Parameter NUM_IRQ, default 4, number of platform interrupt lines (legal range 1..16).
REQ-002 clk  input  1  rising-edge clock; only clock in the block.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 irq_ext, irq_timer  input  1 each  level interrupt requests; irq_ext maps to mip[11], irq_timer maps to mip[7].
REQ-005 irq_plat  input  NUM_IRQ  platform interrupt lines; line i maps to mip[16+i].
REQ-006 op  input  3  CSR_OP_* code from the shared defines header: WRITE, ECALL, EBREAK, MRET, INTRPT, TRAP, WFI.
REQ-007 funct3_low  input  2  RW/RS/RC select; w_en  input  1  write enable; addr  input  12  CSR address.
REQ-008 pc_addr, w_data, tval  input  32 each  trapping PC, write operand, trap value.
REQ-009 instr_retired  input  1  one instruction retired this cycle.
REQ-010 r_data  output  32  combinational read data; addr_vld, read_only  output  1 each  address decode flags.
REQ-011 intrpt_vld  output  1; intrpt_cause  output  5  highest-priority pending enabled interrupt code.
REQ-012 trap_vec  output  32  trap target; mepc  output  32; wfi_active  output  1.

Function
REQ-013 The block SHALL implement mstatus, misa, mie, mtvec, mstatush, mscratch, mepc, mcause, mtval and mip, plus read-only mvendorid, marchid, mimpid, mhartid and mconfigptr, with masked WARL writes.
REQ-014 The block SHALL apply CSR writes at the clock edge following op=WRITE with w_en=1, where the result is w_data (RW), r_data|w_data (RS) or r_data&~w_data (RC).
REQ-015 mtvec[1:0] SHALL be the mode field; a written mode of 2 or 3 SHALL store 0; mtvec[31:2] is the base.
REQ-016 mip[11], mip[7] and mip[16+NUM_IRQ-1:16] SHALL be loaded from their inputs every cycle and are not software-writable; the remaining mip bits are zero.
REQ-017 Priority SHALL be MEI(11) > MTI(7) > platform line 0 > ... > line NUM_IRQ-1; intrpt_cause SHALL give the winner, or 0 when none.
REQ-018 intrpt_vld SHALL equal mstatus.MIE & |(mie & mip), combinationally.
REQ-019 On ECALL, EBREAK, TRAP or INTRPT: mepc <= pc_addr, MPIE <= MIE, MIE <= 0; mcause SHALL be 11, 3, 2, or {1'b1, 26'b0, intrpt_cause} respectively; mtval <= tval, or 0 for ECALL and INTRPT.
REQ-020 On MRET: MIE <= MPIE, MPIE <= 1, and mcause is left unchanged.
REQ-021 trap_vec SHALL be base + 4*intrpt_cause when mode=1 and op=INTRPT, and base otherwise.
REQ-022 WFI state machine, states IDLE and WAIT:
- IDLE->WAIT on op=WFI.
- WAIT->IDLE in the cycle after |(mie & mip) becomes 1, regardless of mstatus.MIE.
- wfi_active = (state==WAIT).
- An INTRPT op SHALL force IDLE.
REQ-023 If an event op and a CSR write target the same register, the event update SHALL win.

Reset
REQ-024 When rst_n=0 at a clock edge, all writable CSRs SHALL clear to 0, except misa = 32'h40000100.
REQ-025 On the same reset edge, the WFI state SHALL return to IDLE and the counters SHALL clear to 0.
REQ-026 Out of reset: intrpt_vld=0, wfi_active=0, mepc=0, trap_vec=0.
REQ-027 Reset SHALL override any op, write or counter increment in the same cycle.

Configuration
REQ-028 When OTTER_CSR_COUNTERS_EN is defined, the block SHALL include 64-bit mcycle (0xB00/0xB80) and minstret (0xB02/0xB82), read-write.
REQ-029 With OTTER_CSR_COUNTERS_EN defined, mcycle SHALL increment every cycle.
REQ-030 With OTTER_CSR_COUNTERS_EN defined, minstret SHALL increment on instr_retired, except in cycles where op is ECALL, EBREAK, TRAP or INTRPT.
REQ-031 With OTTER_CSR_COUNTERS_EN defined, the low word SHALL carry into the high word, and the counters SHALL wrap from 2^64-1 to 0.
REQ-032 With OTTER_CSR_COUNTERS_EN defined, a write to any counter half SHALL replace that half and suppress that cycle's increment of that counter.
REQ-033 When OTTER_CSR_COUNTERS_EN is not defined, the counter addresses SHALL decode as addr_vld=0 and r_data=0, and no counter flops SHALL exist.

Verification
REQ-034 Reset then read misa -> r_data=32'h40000100, addr_vld=1, read_only=0; read mvendorid -> read_only=1.
REQ-035 mtvec<=0x1001, mie[7]=mie[17]=1, MIE=1, irq_timer=1, irq_plat[1]=1, op=INTRPT -> intrpt_cause=7, trap_vec=0x101C, mcause=0x80000007, MIE=0, MPIE=1.
REQ-036 ECALL at pc 0x200 then MRET -> mepc=0x200, mcause=11, mtval=0; after MRET MIE restored to 1, MPIE=1.
REQ-037 WFI with MIE=0, mie[11]=1, irq_ext asserted 5 cycles later -> wfi_active high 6 cycles, intrpt_vld=0 throughout.
REQ-038 Counters enabled: mcycle<=0xFFFFFFFF_FFFFFFFE -> reads ...FFFF next cycle, then 0; RS write to mip[11] with irq_ext=0 -> mip[11] stays 0.

Source files
------------

// File: rtl/otter_trap_csr_if.sv
// CSR access, trap-event and interrupt-line bundle between the core pipeline and otter_trap_csr.
// master drives ops, operands and IRQ levels; slave returns read data, decode flags and trap outputs.
interface otter_trap_csr_if #(
  parameter int NUM_IRQ = 4
);
  logic               irq_ext;
  logic               irq_timer;
  logic [NUM_IRQ-1:0] irq_plat;
  logic [2:0]         op;
  logic [1:0]         funct3_low;
  logic               w_en;
  logic [11:0]        addr;
  logic [31:0]        pc_addr;
  logic [31:0]        w_data;
  logic [31:0]        tval;
  logic               instr_retired;
  logic [31:0]        r_data;
  logic               addr_vld;
  logic               read_only;
  logic               intrpt_vld;
  logic [4:0]         intrpt_cause;
  logic [31:0]        trap_vec;
  logic [31:0]        mepc;
  logic               wfi_active;

  modport master (
    output irq_ext, irq_timer, irq_plat, op, funct3_low, w_en, addr,
           pc_addr, w_data, tval, instr_retired,
    input  r_data, addr_vld, read_only, intrpt_vld, intrpt_cause,
           trap_vec, mepc, wfi_active
  );

  modport slave (
    input  irq_ext, irq_timer, irq_plat, op, funct3_low, w_en, addr,
           pc_addr, w_data, tval, instr_retired,
    output r_data, addr_vld, read_only, intrpt_vld, intrpt_cause,
           trap_vec, mepc, wfi_active
  );
endinterface

// File: rtl/otter_trap_csr.sv
// Machine-mode trap CSRs, interrupt priority and WFI tracking; mcycle/minstret exist only with OTTER_CSR_COUNTERS_EN.
// Reads/decode are combinational, writes and trap updates land on the next clk edge; no backpressure, one op per cycle.
module otter_trap_csr #(
  parameter int NUM_IRQ = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  otter_trap_csr_if.slave bus
);

  localparam logic [2:0] CSR_OP_WRITE  = 3'd1;
  localparam logic [2:0] CSR_OP_ECALL  = 3'd2;
  localparam logic [2:0] CSR_OP_EBREAK = 3'd3;
  localparam logic [2:0] CSR_OP_MRET   = 3'd4;
  localparam logic [2:0] CSR_OP_INTRPT = 3'd5;
  localparam logic [2:0] CSR_OP_TRAP   = 3'd6;
  localparam logic [2:0] CSR_OP_WFI    = 3'd7;

  localparam logic [11:0] A_MSTATUS    = 12'h300;
  localparam logic [11:0] A_MISA       = 12'h301;
  localparam logic [11:0] A_MIE        = 12'h304;
  localparam logic [11:0] A_MTVEC      = 12'h305;
  localparam logic [11:0] A_MSTATUSH   = 12'h310;
  localparam logic [11:0] A_MSCRATCH   = 12'h340;
  localparam logic [11:0] A_MEPC       = 12'h341;
  localparam logic [11:0] A_MCAUSE     = 12'h342;
  localparam logic [11:0] A_MTVAL      = 12'h343;
  localparam logic [11:0] A_MIP        = 12'h344;
  localparam logic [11:0] A_MVENDORID  = 12'hF11;
  localparam logic [11:0] A_MARCHID    = 12'hF12;
  localparam logic [11:0] A_MIMPID     = 12'hF13;
  localparam logic [11:0] A_MHARTID    = 12'hF14;
  localparam logic [11:0] A_MCONFIGPTR = 12'hF15;
`ifdef OTTER_CSR_COUNTERS_EN
  localparam logic [11:0] A_MCYCLE     = 12'hB00;
  localparam logic [11:0] A_MINSTRET   = 12'hB02;
  localparam logic [11:0] A_MCYCLEH    = 12'hB80;
  localparam logic [11:0] A_MINSTRETH  = 12'hB82;
`endif

  localparam logic [31:0] MISA_VAL = 32'h4000_0100;
  // MEI, MTI and the platform lines; wraps correctly to 0xFFFF0000 when NUM_IRQ=16
  localparam logic [31:0] IRQ_MASK = ((32'h1 << (16 + NUM_IRQ)) - 32'h0001_0000) | 32'h0000_0880;

  typedef enum logic {
    WFI_IDLE,
    WFI_WAIT
  } wfi_state_t;

  logic        mstat_mie;
  logic        mstat_mpie;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [31:0] mip_q;
  wfi_state_t  wfi_state;
  wfi_state_t  wfi_state_n;

`ifdef OTTER_CSR_COUNTERS_EN
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;
`endif

  logic [31:0] mstatus_val;
  logic [31:0] rd;
  logic        vld;
  logic        ro;
  logic [31:0] wval;
  logic        wr;
  logic        is_trap;
  logic [31:0] irq_vec;
  logic [31:0] pend;
  logic [4:0]  cause;
  logic [31:0] cause_n;
  logic [31:0] tval_n;
  logic [31:0] base;
  logic [31:0] vec_ofs;

  assign mstatus_val = {24'd0, mstat_mpie, 3'd0, mstat_mie, 3'd0};

  always_comb begin
    rd  = 32'h0;
    vld = 1'b1;
    case (bus.addr)
      A_MSTATUS:  rd = mstatus_val;
      A_MISA:     rd = MISA_VAL;
      A_MIE:      rd = mie_q;
      A_MTVEC:    rd = mtvec_q;
      A_MSCRATCH: rd = mscratch_q;
      A_MEPC:     rd = mepc_q;
      A_MCAUSE:   rd = mcause_q;
      A_MTVAL:    rd = mtval_q;
      A_MIP:      rd = mip_q;
      A_MSTATUSH, A_MVENDORID, A_MARCHID, A_MIMPID, A_MHARTID, A_MCONFIGPTR:
                  rd = 32'h0;
`ifdef OTTER_CSR_COUNTERS_EN
      A_MCYCLE:    rd = mcycle_q[31:0];
      A_MCYCLEH:   rd = mcycle_q[63:32];
      A_MINSTRET:  rd = minstret_q[31:0];
      A_MINSTRETH: rd = minstret_q[63:32];
`endif
      default:    vld = 1'b0;
    endcase
  end

  // the 0xC00-0xFFF quadrant is read-only by address encoding
  assign ro = vld & (bus.addr[11:10] == 2'b11);

  always_comb begin
    case (bus.funct3_low)
      2'b10:   wval = rd | bus.w_data;
      2'b11:   wval = rd & ~bus.w_data;
      default: wval = bus.w_data;
    endcase
  end

  assign wr      = (bus.op == CSR_OP_WRITE) & bus.w_en & vld & ~ro;
  assign is_trap = (bus.op == CSR_OP_ECALL) | (bus.op == CSR_OP_EBREAK) |
                   (bus.op == CSR_OP_TRAP)  | (bus.op == CSR_OP_INTRPT);

  always_comb begin
    irq_vec                  = 32'h0;
    irq_vec[11]              = bus.irq_ext;
    irq_vec[7]               = bus.irq_timer;
    irq_vec[16 +: NUM_IRQ]   = bus.irq_plat;
  end

  assign pend = mie_q & mip_q;

  // lowest priority assigned first so higher-priority sources overwrite it
  always_comb begin
    cause = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[16 + i]) cause = 5'(16 + i);
    end
    if (pend[7])  cause = 5'd7;
    if (pend[11]) cause = 5'd11;
  end

  always_comb begin
    case (bus.op)
      CSR_OP_ECALL:  cause_n = 32'd11;
      CSR_OP_EBREAK: cause_n = 32'd3;
      CSR_OP_TRAP:   cause_n = 32'd2;
      default:       cause_n = {1'b1, 26'd0, cause};
    endcase
    tval_n = ((bus.op == CSR_OP_EBREAK) || (bus.op == CSR_OP_TRAP)) ? bus.tval : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstat_mie  <= 1'b0;
      mstat_mpie <= 1'b0;
      mie_q      <= 32'h0;
      mtvec_q    <= 32'h0;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
      mip_q      <= 32'h0;
    end else begin
      mip_q <= irq_vec;
      if (wr) begin
        case (bus.addr)
          A_MSTATUS: begin
            mstat_mie  <= wval[3];
            mstat_mpie <= wval[7];
          end
          A_MIE:      mie_q      <= wval & IRQ_MASK;
          A_MTVEC:    mtvec_q    <= {wval[31:2], (wval[1] ? 2'b00 : wval[1:0])};
          A_MSCRATCH: mscratch_q <= wval;
          A_MEPC:     mepc_q     <= wval;
          A_MCAUSE:   mcause_q   <= wval;
          A_MTVAL:    mtval_q    <= wval;
          default: ;
        endcase
      end
      // event updates come last so they take precedence over a same-register write
      if (is_trap) begin
        mepc_q     <= bus.pc_addr;
        mstat_mpie <= mstat_mie;
        mstat_mie  <= 1'b0;
        mcause_q   <= cause_n;
        mtval_q    <= tval_n;
      end else if (bus.op == CSR_OP_MRET) begin
        mstat_mie  <= mstat_mpie;
        mstat_mpie <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wfi_state <= WFI_IDLE;
    else        wfi_state <= wfi_state_n;
  end

  always_comb begin
    wfi_state_n = wfi_state;
    case (wfi_state)
      WFI_IDLE: if (bus.op == CSR_OP_WFI) wfi_state_n = WFI_WAIT;
      WFI_WAIT: if (|pend) wfi_state_n = WFI_IDLE;
      default:  wfi_state_n = WFI_IDLE;
    endcase
    if (bus.op == CSR_OP_INTRPT) wfi_state_n = WFI_IDLE;
  end

`ifdef OTTER_CSR_COUNTERS_EN
  logic cyc_lo_wr, cyc_hi_wr, ins_lo_wr, ins_hi_wr;
  assign cyc_lo_wr = wr & (bus.addr == A_MCYCLE);
  assign cyc_hi_wr = wr & (bus.addr == A_MCYCLEH);
  assign ins_lo_wr = wr & (bus.addr == A_MINSTRET);
  assign ins_hi_wr = wr & (bus.addr == A_MINSTRETH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      if (cyc_lo_wr)      mcycle_q[31:0]  <= wval;
      else if (cyc_hi_wr) mcycle_q[63:32] <= wval;
      else                mcycle_q        <= mcycle_q + 64'd1;

      if (ins_lo_wr)      minstret_q[31:0]  <= wval;
      else if (ins_hi_wr) minstret_q[63:32] <= wval;
      else if (bus.instr_retired && !is_trap)
                          minstret_q        <= minstret_q + 64'd1;
    end
  end
`else
  logic unused_retired;
  assign unused_retired = bus.instr_retired;
`endif

  assign base    = {mtvec_q[31:2], 2'b00};
  assign vec_ofs = ((mtvec_q[1:0] == 2'b01) && (bus.op == CSR_OP_INTRPT)) ?
                   {25'd0, cause, 2'b00} : 32'd0;

  assign bus.r_data       = rd;
  assign bus.addr_vld     = vld;
  assign bus.read_only    = ro;
  assign bus.intrpt_vld   = mstat_mie & (|pend);
  assign bus.intrpt_cause = cause;
  assign bus.trap_vec     = base + vec_ofs;
  assign bus.mepc         = mepc_q;
  assign bus.wfi_active   = (wfi_state == WFI_WAIT);

endmodule

// File: tb/tb_otter_trap_csr.sv
// Directed and randomized checks of otter_trap_csr against a CSR-map reference model.
module tb_otter_trap_csr;
  localparam int NI = 4;
  localparam logic [2:0] OP_NOP = 3'd0, OP_WRITE = 3'd1, OP_ECALL = 3'd2, OP_EBREAK = 3'd3,
                         OP_MRET = 3'd4, OP_INTRPT = 3'd5, OP_TRAP = 3'd6, OP_WFI = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  otter_trap_csr_if #(.NUM_IRQ(NI)) bus ();
  otter_trap_csr #(.NUM_IRQ(NI)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_vec = 0;
  int n_mis = 0;

  // reference model: writable CSRs by address, plus interrupt/WFI/counter state
  logic [31:0] m_csr [logic [11:0]];
  logic [31:0] m_mip;
  bit          m_wfi;
  logic [63:0] m_cyc, m_ins;
  bit          cyc_wr, ins_wr;
  int          prio [$];
  logic [31:0] irq_mask;
  logic [11:0] addr_tab [0:19] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h310, 12'h340,
                                   12'h341, 12'h342, 12'h343, 12'h344, 12'hF11, 12'hF12,
                                   12'hF13, 12'hF14, 12'hF15, 12'hB00, 12'hB02, 12'hB80,
                                   12'hB82, 12'h7C0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_csr[12'h300] = 32'h0; m_csr[12'h304] = 32'h0; m_csr[12'h305] = 32'h0;
    m_csr[12'h340] = 32'h0; m_csr[12'h341] = 32'h0; m_csr[12'h342] = 32'h0;
    m_csr[12'h343] = 32'h0;
    m_mip = 32'h0; m_wfi = 1'b0; m_cyc = 64'd0; m_ins = 64'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a, output bit v);
    v = 1'b1;
    if (a == 12'h301) return 32'h4000_0100;
    if (a == 12'h344) return m_mip;
    if (a == 12'h310 || (a >= 12'hF11 && a <= 12'hF15)) return 32'h0;
`ifdef OTTER_CSR_COUNTERS_EN
    if (a == 12'hB00) return m_cyc[31:0];
    if (a == 12'hB80) return m_cyc[63:32];
    if (a == 12'hB02) return m_ins[31:0];
    if (a == 12'hB82) return m_ins[63:32];
`endif
    if (m_csr.exists(a)) return m_csr[a];
    v = 1'b0;
    return 32'h0;
  endfunction

  function automatic logic [4:0] m_cause();
    logic [31:0] p;
    p = m_csr[12'h304] & m_mip;
    foreach (prio[k]) if (p[prio[k]]) return 5'(prio[k]);
    return 5'd0;
  endfunction

  function automatic void m_write(input logic [11:0] a, input logic [31:0] d);
    case (a)
      12'h300: m_csr[a] = d & 32'h0000_0088;
      12'h304: m_csr[a] = d & irq_mask;
      12'h305: m_csr[a] = (d[1:0] >= 2'd2) ? (d & 32'hFFFF_FFFC) : d;
      12'h340, 12'h341, 12'h342, 12'h343: m_csr[a] = d;
`ifdef OTTER_CSR_COUNTERS_EN
      12'hB00: begin m_cyc[31:0]  = d; cyc_wr = 1'b1; end
      12'hB80: begin m_cyc[63:32] = d; cyc_wr = 1'b1; end
      12'hB02: begin m_ins[31:0]  = d; ins_wr = 1'b1; end
      12'hB82: begin m_ins[63:32] = d; ins_wr = 1'b1; end
`endif
      default: ;
    endcase
  endfunction

  task automatic m_step();
    bit v;
    bit trap;
    logic [31:0] rv, nv, st, pend;
    logic [4:0] c;
    if (!rst_n) begin
      m_reset();
      return;
    end
    pend = m_csr[12'h304] & m_mip;
    c = m_cause();
    st = m_csr[12'h300];
    cyc_wr = 1'b0;
    ins_wr = 1'b0;
    trap = (bus.op == OP_ECALL) || (bus.op == OP_EBREAK) || (bus.op == OP_TRAP) || (bus.op == OP_INTRPT);
    if (bus.op == OP_WRITE && bus.w_en) begin
      rv = m_read(bus.addr, v);
      if (v && bus.addr[11:10] != 2'b11) begin
        case (bus.funct3_low)
          2'd2:    nv = rv | bus.w_data;
          2'd3:    nv = rv & ~bus.w_data;
          default: nv = bus.w_data;
        endcase
        m_write(bus.addr, nv);
      end
    end
    if (trap) begin
      m_csr[12'h341] = bus.pc_addr;
      m_csr[12'h300] = st[3] ? 32'h80 : 32'h0;
      case (bus.op)
        OP_ECALL:  begin m_csr[12'h342] = 32'd11; m_csr[12'h343] = 32'h0; end
        OP_EBREAK: begin m_csr[12'h342] = 32'd3;  m_csr[12'h343] = bus.tval; end
        OP_TRAP:   begin m_csr[12'h342] = 32'd2;  m_csr[12'h343] = bus.tval; end
        default:   begin m_csr[12'h342] = 32'h8000_0000 | 32'(c); m_csr[12'h343] = 32'h0; end
      endcase
    end else if (bus.op == OP_MRET) begin
      m_csr[12'h300] = 32'h80 | (st[7] ? 32'h8 : 32'h0);
    end
    if (bus.op == OP_INTRPT) m_wfi = 1'b0;
    else if (m_wfi) begin
      if (pend != 0) m_wfi = 1'b0;
    end else if (bus.op == OP_WFI) m_wfi = 1'b1;
    if (!cyc_wr) m_cyc = m_cyc + 64'd1;
    if (!ins_wr && bus.instr_retired && !trap) m_ins = m_ins + 64'd1;
    m_mip = 32'h0;
    m_mip[11] = bus.irq_ext;
    m_mip[7] = bus.irq_timer;
    for (int i = 0; i < NI; i++) m_mip[16 + i] = bus.irq_plat[i];
  endtask

  task automatic check_all();
    bit v;
    logic [31:0] exp_rd, base, tv, st;
    logic [4:0] c;
    exp_rd = m_read(bus.addr, v);
    c = m_cause();
    st = m_csr[12'h300];
    base = m_csr[12'h305] & 32'hFFFF_FFFC;
    tv = (m_csr[12'h305][1:0] == 2'd1 && bus.op == OP_INTRPT) ? base + 32'd4 * 32'(c) : base;
    check("r_data", bus.r_data, exp_rd);
    check("addr_vld", 32'(bus.addr_vld), 32'(v));
    check("read_only", 32'(bus.read_only), (v && bus.addr[11:10] == 2'b11) ? 32'd1 : 32'd0);
    check("intrpt_vld", 32'(bus.intrpt_vld),
          (st[3] && ((m_csr[12'h304] & m_mip) != 0)) ? 32'd1 : 32'd0);
    check("intrpt_cause", 32'(bus.intrpt_cause), 32'(c));
    check("trap_vec", bus.trap_vec, tv);
    check("mepc", bus.mepc, m_csr[12'h341]);
    check("wfi_active", 32'(bus.wfi_active), 32'(m_wfi));
  endtask

  task automatic step_edge();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    step_edge();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] f3);
    bus.op = OP_WRITE; bus.w_en = 1'b1; bus.addr = a; bus.w_data = d; bus.funct3_low = f3;
    tick();
    bus.op = OP_NOP; bus.w_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.addr = a;
    @(negedge clk);
    check_all();
    check(tag, bus.r_data, exp);
    step_edge();
  endtask

  initial begin
    int cnt;
    bus.irq_ext = 0; bus.irq_timer = 0; bus.irq_plat = '0; bus.op = OP_NOP;
    bus.funct3_low = 2'd1; bus.w_en = 0; bus.addr = 12'h301; bus.pc_addr = 0;
    bus.w_data = 0; bus.tval = 0; bus.instr_retired = 0;
    prio.push_back(11);
    prio.push_back(7);
    for (int i = 0; i < NI; i++) prio.push_back(16 + i);
    irq_mask = 32'h0;
    foreach (prio[k]) irq_mask[prio[k]] = 1'b1;
    m_reset();

    // reset and decode
    step_edge();
    step_edge();
    rst_n = 1'b1;
    @(negedge clk);
    check("misa_reset", bus.r_data, 32'h4000_0100);
    check("misa_vld", 32'(bus.addr_vld), 32'd1);
    check("misa_ro", 32'(bus.read_only), 32'd0);
    check("rst_intrpt_vld", 32'(bus.intrpt_vld), 32'd0);
    check("rst_wfi", 32'(bus.wfi_active), 32'd0);
    check("rst_mepc", bus.mepc, 32'd0);
    check("rst_trap_vec", bus.trap_vec, 32'd0);
    step_edge();
    bus.addr = 12'hF11;
    @(negedge clk);
    check("mvendorid_ro", 32'(bus.read_only), 32'd1);
    check("mvendorid_vld", 32'(bus.addr_vld), 32'd1);
    step_edge();

    // WARL masks
    wr(12'h305, 32'h0000_1002, 2'd1);
    rd("mtvec_mode2", 12'h305, 32'h0000_1000);
    wr(12'h304, 32'hFFFF_FFFF, 2'd1);
    rd("mie_mask", 12'h304, 32'h000F_0880);
    wr(12'h304, 32'h0000_0080, 2'd3);
    rd("mie_rc", 12'h304, 32'h000F_0800);
    wr(12'h300, 32'hFFFF_FFFF, 2'd1);
    rd("mstatus_mask", 12'h300, 32'h0000_0088);
    wr(12'h300, 32'h0000_0008, 2'd3);
    rd("mstatus_rc", 12'h300, 32'h0000_0080);

    // vectored interrupt
    wr(12'h305, 32'h0000_1001, 2'd1);
    wr(12'h304, 32'h0002_0080, 2'd1);
    wr(12'h300, 32'h0000_0008, 2'd1);
    bus.irq_timer = 1'b1; bus.irq_plat = 4'b0010;
    tick();
    bus.op = OP_INTRPT;
    @(negedge clk);
    check_all();
    check("irq_cause", 32'(bus.intrpt_cause), 32'd7);
    check("irq_vec", bus.trap_vec, 32'h0000_101C);
    check("irq_vld", 32'(bus.intrpt_vld), 32'd1);
    step_edge();
    bus.op = OP_NOP; bus.irq_timer = 1'b0; bus.irq_plat = '0;
    rd("irq_mcause", 12'h342, 32'h8000_0007);
    rd("irq_mstatus", 12'h300, 32'h0000_0080);

    // ECALL / MRET / EBREAK / TRAP
    wr(12'h300, 32'h0000_0008, 2'd1);
    bus.pc_addr = 32'h200; bus.tval = 32'hDEAD_BEEF; bus.op = OP_ECALL;
    tick();
    bus.op = OP_NOP;
    rd("ecall_mepc", 12'h341, 32'h200);
    check("ecall_mepc_port", bus.mepc, 32'h200);
    rd("ecall_mcause", 12'h342, 32'd11);
    rd("ecall_mtval", 12'h343, 32'd0);
    rd("ecall_mstatus", 12'h300, 32'h80);
    bus.op = OP_MRET;
    tick();
    bus.op = OP_NOP;
    rd("mret_mstatus", 12'h300, 32'h88);
    rd("mret_mcause", 12'h342, 32'd11);
    bus.pc_addr = 32'h304; bus.tval = 32'h55; bus.op = OP_EBREAK;
    tick();
    bus.op = OP_NOP;
    rd("ebreak_mcause", 12'h342, 32'd3);
    rd("ebreak_mtval", 12'h343, 32'h55);
    bus.tval = 32'h77; bus.op = OP_TRAP;
    tick();
    bus.op = OP_NOP;
    rd("trap_mcause", 12'h342, 32'd2);
    rd("trap_mtval", 12'h343, 32'h77);

    // WFI wake with global MIE clear
    wr(12'h300, 32'h0, 2'd1);
    wr(12'h304, 32'h0000_0800, 2'd1);
    bus.op = OP_WFI;
    tick();
    bus.op = OP_NOP;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) bus.irq_ext = 1'b1;
      @(negedge clk);
      check_all();
      if (bus.wfi_active) cnt++;
      check("wfi_no_intrpt", 32'(bus.intrpt_vld), 32'd0);
      step_edge();
    end
    check("wfi_cycles", 32'(cnt), 32'd6);
    bus.irq_ext = 1'b0;
    tick();

    // mip is not software-writable
    wr(12'h344, 32'h0000_0800, 2'd2);
    rd("mip_rs", 12'h344, 32'h0);

`ifdef OTTER_CSR_COUNTERS_EN
    wr(12'hB00, 32'hFFFF_FFFE, 2'd1);
    wr(12'hB80, 32'hFFFF_FFFF, 2'd1);
    tick();
    rd("mcycle_lo_max", 12'hB00, 32'hFFFF_FFFF);
    rd("mcycle_hi_wrap", 12'hB80, 32'h0);
`else
    bus.addr = 12'hB00;
    @(negedge clk);
    check("mcycle_absent_vld", 32'(bus.addr_vld), 32'd0);
    check("mcycle_absent_rd", bus.r_data, 32'd0);
    step_edge();
`endif

    // reset wins over a same-cycle write
    wr(12'h340, 32'h0000_1234, 2'd1);
    rd("mscratch_wr", 12'h340, 32'h1234);
    rst_n = 1'b0;
    wr(12'h340, 32'h0000_5678, 2'd1);
    rst_n = 1'b1;
    rd("mscratch_rst", 12'h340, 32'h0);
    rd("misa_rst2", 12'h301, 32'h4000_0100);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r <= 5)       bus.op = OP_WRITE;
      else if (r == 6)  bus.op = OP_ECALL;
      else if (r == 7)  bus.op = OP_EBREAK;
      else if (r == 8)  bus.op = OP_MRET;
      else if (r == 9)  bus.op = OP_INTRPT;
      else if (r == 10) bus.op = OP_TRAP;
      else if (r == 11) bus.op = OP_WFI;
      else              bus.op = OP_NOP;
      bus.addr = addr_tab[$urandom_range(0, 19)];
      bus.w_en = 1'($urandom);
      bus.funct3_low = 2'($urandom);
      bus.w_data = $urandom;
      bus.pc_addr = $urandom;
      bus.tval = $urandom;
      bus.instr_retired = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        bus.irq_ext = 1'($urandom);
        bus.irq_timer = 1'($urandom);
        bus.irq_plat = 4'($urandom);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
